// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bundle for seven_seg_scan_ctrl: value/load/enable in, segments/anodes/frame pulse out.
// master drives the inputs (datapath side); slave is the scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enableIn;
    logic [4*NUM_DIGITS-1:0] valueIn;
    logic                    loadIn;
    logic [6:0]              segOut;
    logic [NUM_DIGITS-1:0]   anodeOut;
    logic                    frameDoneOut;

    modport master (
        output enableIn, valueIn, loadIn,
        input  segOut, anodeOut, frameDoneOut
    );

    modport slave (
        input  enableIn, valueIn, loadIn,
        output segOut, anodeOut, frameDoneOut
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// N-digit common-anode 7-segment scan controller with frame-synchronous double buffering.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits above digit 0).
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_ctrl_if.slave bus,
    output logic [1:0]           o_state
);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DW      = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

    state_t          r_state, w_nxt_state;
    logic [IW-1:0]   r_idx, w_nxt_idx;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic [DW-1:0]   r_disp, w_nxt_disp;
    logic [DW-1:0]   r_pend, w_nxt_pend;
    logic            r_pflag, w_nxt_pflag;
    logic [6:0]      r_seg, w_seg;
    logic [NUM_DIGITS-1:0] r_anode, w_anode;
    logic            r_fd;
    logic            w_wrap, w_start, w_lz;
    logic [3:0]      w_nib;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'h40;  4'h1: f_decode = 7'h79;
            4'h2: f_decode = 7'h24;  4'h3: f_decode = 7'h30;
            4'h4: f_decode = 7'h19;  4'h5: f_decode = 7'h12;
            4'h6: f_decode = 7'h02;  4'h7: f_decode = 7'h78;
            4'h8: f_decode = 7'h00;  4'h9: f_decode = 7'h18;
            4'hA: f_decode = 7'h08;  4'hB: f_decode = 7'h03;
            4'hC: f_decode = 7'h46;  4'hD: f_decode = 7'h21;
            4'hE: f_decode = 7'h06;  default: f_decode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_pend  <= '0;
            r_pflag <= 1'b0;
            r_seg   <= 7'h7F;
            r_anode <= '1;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_disp  <= w_nxt_disp;
            r_pend  <= w_nxt_pend;
            r_pflag <= w_nxt_pflag;
            r_seg   <= w_seg;
            r_anode <= w_anode;
            r_fd    <= w_wrap;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        w_wrap      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.enableIn) begin
                    w_nxt_state = S_SHOW;
                    w_nxt_idx   = '0;
                    w_nxt_cnt   = '0;
                    w_start     = 1'b1;
                end
            end
            S_SHOW, S_BLANK: begin
                if (!bus.enableIn) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_idx   = '0;
                    w_nxt_cnt   = '0;
                end else if (r_state == S_SHOW && r_cnt != SCAN_LAST) begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end else if (r_state == S_BLANK && r_cnt != BLANK_LAST) begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end else if (r_state == S_SHOW && BLANK_CYC > 0) begin
                    w_nxt_state = S_BLANK;
                    w_nxt_cnt   = '0;
                end else begin
                    // End of this digit's last dwell: step to the next digit or wrap the frame.
                    w_nxt_state = S_SHOW;
                    w_nxt_cnt   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_nxt_idx = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_nxt_idx = r_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_idx   = '0;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // A load on a swap edge bypasses the pending buffer so it appears without a frame of delay.
    always_comb begin
        w_nxt_disp  = r_disp;
        w_nxt_pend  = r_pend;
        w_nxt_pflag = r_pflag;
        if (w_wrap || w_start) begin
            if (bus.loadIn)
                w_nxt_disp = bus.valueIn;
            else if (r_pflag)
                w_nxt_disp = r_pend;
            w_nxt_pflag = 1'b0;
        end else if (bus.loadIn) begin
            w_nxt_pend  = bus.valueIn;
            w_nxt_pflag = 1'b1;
        end
    end

    always_comb begin
        w_anode = '1;
        w_seg   = 7'h7F;
        w_nib   = w_nxt_disp[int'(w_nxt_idx)*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        w_lz = (w_nxt_idx != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(w_nxt_idx) && w_nxt_disp[j*4 +: 4] != 4'h0)
                w_lz = 1'b0;
        end
`else
        w_lz = 1'b0;
`endif
        if (w_nxt_state == S_SHOW && !w_lz) begin
            w_anode[w_nxt_idx] = 1'b0;
            w_seg              = f_decode(w_nib);
        end
    end

    assign bus.segOut       = r_seg;
    assign bus.anodeOut     = r_anode;
    assign bus.frameDoneOut = r_fd;
    assign o_state          = r_state;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Table-driven bench for seven_seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1).
module tb_seven_seg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] o_state;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .o_state (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    vec_t vec_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic en, input logic ld, input logic [15:0] val,
                        input logic [3:0] an, input logic [6:0] seg, input logic fd);
        vec_t v;
        v.en = en; v.ld = ld; v.val = val; v.an = an; v.seg = seg; v.fd = fd;
        vec_q.push_back(v);
    endtask

    // Expected outputs for the first n cycles of a frame showing value v.
    task automatic add_frame(input logic [15:0] v, input logic fd0, input int n);
        int k = 0;
        for (int d = 0; d < 4; d++) begin
            logic [15:0] upper = v >> (4 * d);
            logic [3:0]  an    = 4'hF;
            logic [6:0]  seg   = seg_of(upper[3:0]);
            logic        sup   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            sup = (d > 0) && (upper == 16'h0);
`endif
            if (!sup) an[d] = 1'b0;
            else      seg   = 7'h7F;
            for (int c = 0; c < 5; c++) begin
                if (k < n) begin
                    if (c < 4) push(1'b1, 1'b0, 16'h0, an, seg, (k == 0) ? fd0 : 1'b0);
                    else       push(1'b1, 1'b0, 16'h0, 4'hF, 7'h7F, 1'b0);
                end
                k++;
            end
        end
    endtask

    task automatic set_load(input int idx, input logic [15:0] val);
        vec_t v = vec_q[idx];
        v.ld  = 1'b1;
        v.val = val;
        vec_q[idx] = v;
    endtask

    task automatic chk_dark(input string name);
        chk({name, "_anode"}, 32'(bus.anodeOut), 32'hF);
        chk({name, "_seg"}, 32'(bus.segOut), 32'h7F);
        chk({name, "_fd"}, 32'(bus.frameDoneOut), 32'h0);
    endtask

    initial begin
        int base;
        bus.enableIn = 1'b0;
        bus.loadIn   = 1'b0;
        bus.valueIn  = 16'h0;

        push(1'b0, 1'b1, 16'h1234, 4'hF, 7'h7F, 1'b0);
        add_frame(16'h1234, 1'b0, 20);
        base = vec_q.size();
        add_frame(16'h1234, 1'b1, 20);
        set_load(base + 6, 16'hABCD);
        add_frame(16'hABCD, 1'b1, 20);
        base = vec_q.size();
        add_frame(16'h5678, 1'b1, 11);
        set_load(base, 16'h5678);
        push(1'b0, 1'b0, 16'h0, 4'hF, 7'h7F, 1'b0);
        push(1'b0, 1'b0, 16'h0, 4'hF, 7'h7F, 1'b0);
        base = vec_q.size();
        add_frame(16'h5678, 1'b0, 20);
        set_load(base + 3, 16'h0050);
        add_frame(16'h0050, 1'b1, 20);
        add_frame(16'h0050, 1'b1, 1);

        repeat (2) @(posedge clk);
        #1 chk_dark("reset");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < vec_q.size(); i++) begin
            @(negedge clk);
            bus.enableIn = vec_q[i].en;
            bus.loadIn   = vec_q[i].ld;
            bus.valueIn  = vec_q[i].val;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_anode", i), 32'(bus.anodeOut), 32'(vec_q[i].an));
            chk($sformatf("v%0d_seg", i), 32'(bus.segOut), 32'(vec_q[i].seg));
            chk($sformatf("v%0d_fd", i), 32'(bus.frameDoneOut), 32'(vec_q[i].fd));
        end

        // Mid-run async reset discards a pending load and darkens outputs immediately.
        @(negedge clk);
        bus.loadIn  = 1'b1;
        bus.valueIn = 16'h9999;
        @(posedge clk);
        #1 bus.loadIn = 1'b0;
        #2 rst = 1'b1;
        #1 chk_dark("async_rst");
        bus.enableIn = 1'b0;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk_dark($sformatf("post_rst%0d", i));
        end
        @(negedge clk) bus.enableIn = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_anode", 32'(bus.anodeOut), 32'hE);
        chk("restart_seg", 32'(bus.segOut), 32'h40);
        chk("restart_fd", 32'(bus.frameDoneOut), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
